// File: rtl/serial_paralelo_if.sv
// serial_paralelo_if: lane-side bundle of the per-lane receive deserializer.
//   data_in     : serial lane bit (from the line)
//   data_out    : last completed byte
//   valid_out   : data_out is payload (1) or idle comma (0)
//   byte_strobe : one-cycle pulse per new data_out
//   active      : lane aligned and locked
// master = the side feeding bits and consuming bytes; slave = the deserializer.
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/serial_paralelo.sv
// serial_paralelo: per-lane receive deserializer. Hunts for the idle comma at
// any bit offset, confirms alignment over LOCK_COUNT boundary-aligned commas,
// then emits one byte every 8 bit clocks tagged payload/idle.
// Ports:
//   clk_32f : bit clock, one serial bit per rising edge
//   reset   : asynchronous, active-high
//   lane    : serial_paralelo_if.slave (data_in, data_out, valid_out,
//             byte_strobe, active)
// Parameters: COMMA (alignment/idle character), LOCK_COUNT (1..15).
// Build option: define SP_LSB_FIRST_EN for LSB-first bit order (default MSB first).
module serial_paralelo #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  serial_paralelo_if.slave lane
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HIST_W = BYTE_W - 1;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [HIST_W-1:0]  sr_q;
  logic [BYTE_W-1:0]  w_c;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   comma_cnt_q, comma_cnt_d;
  logic [CNT_W-1:0]   comma_inc_c;
  logic [BYTE_W-1:0]  data_out_q, data_out_d;
  logic               valid_out_q, valid_out_d;
  logic               strobe_q, strobe_d;
  logic               active_q, active_d;
  logic               is_comma_c;
  logic               boundary_c;
  logic               lock_hit_c;

  // Byte completing on this edge. Only the 7 most recent bits are kept, since
  // the oldest bit of the 8-bit history would fall out of the window anyway.
`ifdef SP_LSB_FIRST_EN
  assign w_c = {lane.data_in, sr_q};
`else
  assign w_c = {sr_q, lane.data_in};
`endif

  assign is_comma_c  = (w_c == COMMA);
  assign boundary_c  = (bit_cnt_q == LAST_BIT);
  // Saturating comma count; lock_hit_c flags the comma that completes the run.
  assign comma_inc_c = (comma_cnt_q >= LOCK_CNT) ? LOCK_CNT : comma_cnt_q + CNT_W'(1);
  assign lock_hit_c  = (comma_inc_c == LOCK_CNT);

  // State register.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) state_q <= ST_HUNT;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: begin
        if (is_comma_c) state_d = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_SYNC;
      end
      ST_SYNC: begin
        if (boundary_c) begin
          if (!is_comma_c)     state_d = ST_HUNT;
          else if (lock_hit_c) state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: state_d = ST_ACTIVE;
      default:   state_d = ST_HUNT;
    endcase
  end

  // Output / datapath next values; alignment is frozen once a comma is found.
  always_comb begin
    bit_cnt_d   = bit_cnt_q + BIT_W'(1);
    comma_cnt_d = comma_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    strobe_d    = 1'b0;
    active_d    = active_q;
    case (state_q)
      ST_HUNT: begin
        if (is_comma_c) begin
          bit_cnt_d   = '0;
          comma_cnt_d = CNT_W'(1);
          if (LOCK_COUNT == 1) active_d = 1'b1;
        end
      end
      ST_SYNC: begin
        if (boundary_c) begin
          if (is_comma_c) begin
            comma_cnt_d = comma_inc_c;
            if (lock_hit_c) active_d = 1'b1;
          end else begin
            comma_cnt_d = '0;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary_c) begin
          data_out_d  = w_c;
          valid_out_d = !is_comma_c;
          strobe_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
`ifdef SP_LSB_FIRST_EN
      sr_q        <= w_c[BYTE_W-1:1];
`else
      sr_q        <= w_c[HIST_W-1:0];
`endif
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

  assign lane.data_out    = data_out_q;
  assign lane.valid_out   = valid_out_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: self-checking bench for serial_paralelo. Payload bytes
// sent after lock are queued as {valid, data}; a monitor pops and compares on
// every byte_strobe and checks the 8-cycle strobe spacing.
module tb_serial_paralelo;

  localparam logic [7:0] COMMA = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset;

  serial_paralelo_if lane ();

  serial_paralelo #(.COMMA(COMMA), .LOCK_COUNT(4)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lane    (lane)
  );

  always #5 clk_32f = ~clk_32f;

  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  int         cyc = 0;
  int         last_strobe = 0;
  bit         have_strobe = 1'b0;
  logic [8:0] sb_q[$];
  logic [8:0] sb_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  always @(posedge clk_32f) cyc <= cyc + 1;

  // Scoreboard consumer.
  always @(negedge clk_32f) begin
    if (!reset && lane.byte_strobe) begin
      if (sb_q.size() == 0) begin
        check("strobe_unexpected", 32'(lane.byte_strobe), 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("data_out", 32'(lane.data_out), 32'(sb_exp[7:0]));
        check("valid_out", 32'(lane.valid_out), 32'(sb_exp[8]));
        if (have_strobe) check("strobe_gap", 32'(cyc - last_strobe), 32'd8);
        last_strobe = cyc;
        have_strobe = 1'b1;
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    lane.data_in = b;
    @(posedge clk_32f);
    #1;
    edge_cnt++;
  endtask

  // lock_edge > 0: check active == (edge_cnt >= lock_edge) after each bit.
  // quiet: byte_strobe must stay low after each bit.
  task automatic send_byte(input logic [7:0] b, input bit push, input int lock_edge, input bit quiet);
    for (int i = 0; i < 8; i++) begin
`ifdef SP_LSB_FIRST_EN
      send_bit(b[i]);
`else
      send_bit(b[7-i]);
`endif
      if (lock_edge > 0) check("active", 32'(lane.active), 32'(edge_cnt >= lock_edge));
      if (quiet) check("strobe_quiet", 32'(lane.byte_strobe), 32'd0);
    end
    if (push) sb_q.push_back({(b != COMMA), b});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data_out"}, 32'(lane.data_out), 32'd0);
    check({tag, "_valid_out"}, 32'(lane.valid_out), 32'd0);
    check({tag, "_byte_strobe"}, 32'(lane.byte_strobe), 32'd0);
    check({tag, "_active"}, 32'(lane.active), 32'd0);
  endtask

  task automatic clear_bookkeeping();
    edge_cnt    = 0;
    have_strobe = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_32f);
    reset = 1'b1;
    lane.data_in = 1'b0;
    repeat (n) @(posedge clk_32f);
    #1;
    check_cleared("reset");
    reset = 1'b0;
    clear_bookkeeping();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    lane.data_in = 1'b0;

    // Reset state.
    do_reset(3);

    // Lock: junk 101, then 4 commas; active rises on edge 35.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("junk_active", 32'(lane.active), 32'd0);
    repeat (4) send_byte(COMMA, 1'b0, 35, 1'b1);
    check("lock_edge", 32'(edge_cnt), 32'd35);

    // Data after lock; active must stay high.
    send_byte(8'h4F, 1'b1, 1, 1'b0);
    send_byte(8'hE4, 1'b1, 1, 1'b0);
    send_byte(COMMA, 1'b1, 1, 1'b0);
    send_byte(8'h21, 1'b1, 1, 1'b0);

    // Mid-byte reset at bit_cnt == 3.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("pre_reset_active", 32'(lane.active), 32'd1);
    check("drained_before_reset", 32'(sb_q.size()), 32'd0);
    #1 reset = 1'b1;
    #1 check_cleared("async_reset");
    reset = 1'b0;
    clear_bookkeeping();

    // Relock needs a fresh run of 4 commas (edge 32 from a cleared shifter).
    repeat (4) send_byte(COMMA, 1'b0, 32, 1'b1);
    send_byte(8'h5A, 1'b1, 1, 1'b0);
    send_byte(8'h00, 1'b1, 1, 1'b0);

    // Sync break: BC BC 00 sends the lane back to HUNT; lock at edge 56.
    do_reset(3);
    send_byte(COMMA, 1'b0, 56, 1'b1);
    send_byte(COMMA, 1'b0, 56, 1'b1);
    send_byte(8'h00, 1'b0, 56, 1'b1);
    repeat (4) send_byte(COMMA, 1'b0, 56, 1'b1);
    send_byte(8'h4F, 1'b1, 1, 1'b0);
    send_byte(8'hC3, 1'b1, 1, 1'b0);

    repeat (3) @(negedge clk_32f);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
